// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared constants and types for the cpu memory responder.
//   ADDR_W_DEFAULT : default word-address width (RAM depth 2**ADDR_W words)
//   WORD_W         : RAM / CPU word width in bits
//   ld_state_e     : loader FSM state (LD_LOAD fills RAM, LD_RUN releases the CPU)
package cpu_mem_pkg;

    localparam int ADDR_W_DEFAULT = 10;
    localparam int WORD_W         = 32;

    typedef enum logic {
        LD_LOAD = 1'b0,
        LD_RUN  = 1'b1
    } ld_state_e;

endpackage

// File: rtl/cpu_mem_responder_ld_packer.sv
// ld_packer: packs an accepted byte stream little-endian into 32-bit words.
//   clk, i_reset   : clock, synchronous active-high reset
//   clear_i        : synchronous clear of the partial word
//   byte_valid_i   : a byte is accepted this cycle
//   byte_i         : the accepted byte
//   last_i         : accepted byte is the final one of the stream
//   word_valid_o   : word_o is complete this cycle (4th byte or last byte)
//   word_o         : packed word; bytes not yet received read as zero
//   last_o         : the completing byte carried last
module ld_packer
    import cpu_mem_pkg::*;
(
    input  logic              clk,
    input  logic              i_reset,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    input  logic              last_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o,
    output logic              last_o
);

    logic [1:0]        byte_cnt_q;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] merged;

    // The shift register only ever holds bytes below byte_cnt_q (it is zeroed
    // after each word), so merging in the new byte leaves the upper bytes zero.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        merged = shift_q;
        merged[{byte_cnt_q, 3'b000} +: 8] = byte_i;
    end

    assign word_valid_o = byte_valid_i && ((byte_cnt_q == 2'd3) || last_i);
    assign word_o       = merged;
    assign last_o       = byte_valid_i && last_i;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
        if (i_reset || clear_i) begin
            byte_cnt_q <= 2'd0;
            shift_q    <= '0;
        end else if (byte_valid_i) begin
            if (word_valid_o) begin
                byte_cnt_q <= 2'd0;
                shift_q    <= '0;
            end else begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                shift_q    <= merged;
            end
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: word RAM serving the cpu fetch and data ports, filled
// after reset by a byte-stream loader, which then releases the CPU.
//   clk, i_reset        : clock, synchronous active-high reset
//   pc_addr / pc_data   : fetch byte address / combinational instruction word
//   rd_addr / rd_data   : data read byte address / combinational data word
//   wr_addr, wr_data,
//   wr_valid            : single-cycle CPU write (honoured only in RUN)
//   ld_byte, ld_valid,
//   ld_last / ld_ready  : loader byte stream and handshake (ready only in LOAD)
//   o_running           : CPU release, high in RUN
//   o_fault             : sticky flag for a misaligned or out-of-range CPU write
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic [31:0]       pc_addr,
    output logic [31:0]       pc_data,
    input  logic [31:0]       rd_addr,
    output logic [31:0]       rd_data,
    input  logic [31:0]       wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              wr_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_valid,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              o_running,
    output logic              o_fault
);

    localparam int DEPTH = 2 ** ADDR_W;

    ld_state_e         state_q;
    logic [ADDR_W-1:0] load_ptr_q;
    logic              fault_q;
    logic [WORD_W-1:0] mem [DEPTH];

    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic              word_last;
    logic              wr_legal;
    logic              ld_wr;
    logic              cpu_wr;
    logic              unused_addr_lsbs;

    function automatic logic in_range(input logic [31:0] addr);
        return addr[31:ADDR_W+2] == '0;
    endfunction

    // Reads ignore the byte offset, so those bits only matter for writes.
    assign unused_addr_lsbs = ^{pc_addr[1:0], rd_addr[1:0]};

    // Gated by i_reset so no byte is taken in the cycle the loader is being restarted.
    assign ld_ready = (state_q == LD_LOAD) && !i_reset;

    ld_packer u_packer (
        .clk          (clk),
        .i_reset      (i_reset),
        .clear_i      (state_q == LD_RUN),
        .byte_valid_i (ld_valid && ld_ready),
        .byte_i       (ld_byte),
        .last_i       (ld_last),
        .word_valid_o (word_valid),
        .word_o       (word),
        .last_o       (word_last)
    );

    assign wr_legal = in_range(wr_addr) && (wr_addr[1:0] == 2'b00);
    assign ld_wr    = word_valid;
    assign cpu_wr   = !i_reset && (state_q == LD_RUN) && wr_valid && wr_legal;

    // Loader and CPU writes are mutually exclusive by state: one write port.
    always_ff @(posedge clk) begin
        // NOTE: the RAM is deliberately not reset; contents survive i_reset.
        if (ld_wr) begin
            mem[load_ptr_q] <= word;
        end else if (cpu_wr) begin
            mem[wr_addr[ADDR_W+1:2]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q    <= LD_LOAD;
            load_ptr_q <= '0;
            fault_q    <= 1'b0;
        end else if (state_q == LD_LOAD) begin
            if (word_valid) begin
                // Last word of the stream, or RAM full: stop, never wrap.
                if (word_last || (load_ptr_q == '1)) begin
                    state_q <= LD_RUN;
                end else begin
                    load_ptr_q <= load_ptr_q + 1'b1;
                end
            end
        end else begin
            if (wr_valid && !wr_legal) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign o_running = (state_q == LD_RUN);
    assign o_fault   = fault_q;

    // Old value on a same-cycle write: the write only lands at the next edge.
    assign pc_data = (o_running && in_range(pc_addr)) ? mem[pc_addr[ADDR_W+1:2]] : '0;
    assign rd_data = (o_running && in_range(rd_addr)) ? mem[rd_addr[ADDR_W+1:2]] : '0;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: one instance with ADDR_W=10, one with ADDR_W=2
// (for the full-RAM auto-stop). Expectations are pushed to a scoreboard when
// stimulus is applied; a monitor pops and compares them mid-cycle.
module tb_cpu_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset  [2];
    logic [31:0] pc_addr  [2];
    logic [31:0] rd_addr  [2];
    logic [31:0] wr_addr  [2];
    logic [31:0] wr_data  [2];
    logic        wr_valid [2];
    logic [7:0]  ld_byte  [2];
    logic        ld_valid [2];
    logic        ld_last  [2];
    logic [31:0] pc_data  [2];
    logic [31:0] rd_data  [2];
    logic        ld_ready [2];
    logic        o_running[2];
    logic        o_fault  [2];

    cpu_mem_responder #(.ADDR_W(10)) dut (
        .clk(clk), .i_reset(i_reset[0]),
        .pc_addr(pc_addr[0]), .pc_data(pc_data[0]),
        .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
        .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_valid(wr_valid[0]),
        .ld_byte(ld_byte[0]), .ld_valid(ld_valid[0]), .ld_last(ld_last[0]),
        .ld_ready(ld_ready[0]), .o_running(o_running[0]), .o_fault(o_fault[0])
    );

    cpu_mem_responder #(.ADDR_W(2)) dut_small (
        .clk(clk), .i_reset(i_reset[1]),
        .pc_addr(pc_addr[1]), .pc_data(pc_data[1]),
        .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
        .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_valid(wr_valid[1]),
        .ld_byte(ld_byte[1]), .ld_valid(ld_valid[1]), .ld_last(ld_last[1]),
        .ld_ready(ld_ready[1]), .o_running(o_running[1]), .o_fault(o_fault[1])
    );

    // ---------------- reference model ----------------
    logic [31:0] m_mem   [2][1024];
    bit          m_known [2][1024];
    bit          m_run   [2];
    bit          m_fault [2];
    int          m_ptr   [2];
    int          m_nb    [2];
    logic [7:0]  m_b     [2][4];

    function automatic int aw(int d);
        return (d == 0) ? 10 : 2;
    endfunction

    function automatic int depth(int d);
        return 1 << aw(d);
    endfunction

    function automatic bit in_rng(int d, logic [31:0] a);
        return (a >> (aw(d) + 2)) == 32'd0;
    endfunction

    function automatic int widx(int d, logic [31:0] a);
        return int'(a >> 2) % depth(d);
    endfunction

    // What one clock edge does, from the loader/CPU rules.
    task automatic model_edge(int d);
        logic [31:0] w;
        if (i_reset[d]) begin
            m_run[d] = 0; m_fault[d] = 0; m_ptr[d] = 0; m_nb[d] = 0;
        end else if (!m_run[d]) begin
            if (ld_valid[d]) begin
                m_b[d][m_nb[d]] = ld_byte[d];
                m_nb[d]++;
                if (m_nb[d] == 4 || ld_last[d]) begin
                    w = 32'd0;
                    for (int i = 0; i < m_nb[d]; i++) w = w + (32'(m_b[d][i]) << (8 * i));
                    m_mem[d][m_ptr[d]]   = w;
                    m_known[d][m_ptr[d]] = 1;
                    m_nb[d] = 0;
                    if (ld_last[d] || m_ptr[d] == depth(d) - 1) m_run[d] = 1;
                    else m_ptr[d]++;
                end
            end
        end else if (wr_valid[d]) begin
            if (in_rng(d, wr_addr[d]) && wr_addr[d][1:0] == 2'b00) begin
                m_mem[d][widx(d, wr_addr[d])]   = wr_data[d];
                m_known[d][widx(d, wr_addr[d])] = 1;
            end else begin
                m_fault[d] = 1;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          d;
        string       name;
        logic [31:0] pc;
        logic [31:0] rd;
        bit          chk_pc;
        bit          chk_rd;
        bit          run;
        bit          fault;
        bit          ready;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_read(int d, logic [31:0] a, output logic [31:0] v, output bit known);
        if (!m_run[d] || !in_rng(d, a)) begin
            v = 32'd0; known = 1;
        end else begin
            v = m_mem[d][widx(d, a)]; known = m_known[d][widx(d, a)];
        end
    endtask

    task automatic expect_now(int d, string name);
        exp_t e;
        e.d = d; e.name = name;
        e.run = m_run[d]; e.fault = m_fault[d];
        e.ready = !m_run[d] && !i_reset[d];
        model_read(d, pc_addr[d], e.pc, e.chk_pc);
        model_read(d, rd_addr[d], e.rd, e.chk_rd);
        sb.push_back(e);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.chk_pc) check({mon_e.name, ".pc_data"}, pc_data[mon_e.d], mon_e.pc);
            if (mon_e.chk_rd) check({mon_e.name, ".rd_data"}, rd_data[mon_e.d], mon_e.rd);
            check({mon_e.name, ".o_running"}, 32'(o_running[mon_e.d]), 32'(mon_e.run));
            check({mon_e.name, ".o_fault"},   32'(o_fault[mon_e.d]),   32'(mon_e.fault));
            check({mon_e.name, ".ld_ready"},  32'(ld_ready[mon_e.d]),  32'(mon_e.ready));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic cyc(int d, string name);
        expect_now(d, name);
        tick();
    endtask

    task automatic send_byte(int d, logic [7:0] b, logic last, string name);
        ld_byte[d] = b; ld_valid[d] = 1'b1; ld_last[d] = last;
        cyc(d, name);
        ld_valid[d] = 1'b0; ld_last[d] = 1'b0;
    endtask

    task automatic cpu_write(int d, logic [31:0] a, logic [31:0] v, logic [31:0] ra, string name);
        wr_addr[d] = a; wr_data[d] = v; wr_valid[d] = 1'b1; rd_addr[d] = ra;
        cyc(d, name);
        wr_valid[d] = 1'b0;
    endtask

    task automatic do_reset(int d, string name);
        i_reset[d] = 1'b1;
        cyc(d, name);
        i_reset[d] = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] t1 [8];
        int nbytes;
        int nwords;
        t1 = '{8'h41, 8'h10, 8'hA0, 8'hE3, 8'h00, 8'h00, 8'hA0, 8'hE1};

        for (int d = 0; d < 2; d++) begin
            i_reset[d] = 1'b1; pc_addr[d] = '0; rd_addr[d] = '0; wr_addr[d] = '0;
            wr_data[d] = '0; wr_valid[d] = 1'b0; ld_byte[d] = '0;
            ld_valid[d] = 1'b0; ld_last[d] = 1'b0;
        end
        tick();
        expect_now(0, "reset_cycle");
        expect_now(1, "reset_cycle_small");
        tick();
        i_reset[0] = 1'b0; i_reset[1] = 1'b0;
        cyc(0, "after_reset");

        // 1: full-word load, ld_last without ld_valid ignored
        ld_last[0] = 1'b1;
        cyc(0, "last_without_valid");
        ld_last[0] = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(0, t1[i], i == 7, $sformatf("load1_b%0d", i));
        pc_addr[0] = 32'h0; rd_addr[0] = 32'h4;
        cyc(0, "load1_readback");

        // 3: CPU write, same-cycle read sees the old value
        cpu_write(0, 32'h10, 32'h1234_5678, 32'h10, "wr_pre");
        cpu_write(0, 32'h10, 32'hDEAD_BEEF, 32'h10, "wr_same_cycle");
        cyc(0, "wr_next_cycle");

        // random CPU traffic, legal writes only
        for (int i = 0; i < 150; i++) begin
            wr_valid[0] = 1'($urandom_range(0, 1));
            wr_addr[0]  = 32'($urandom_range(0, 31)) << 2;
            wr_data[0]  = $urandom;
            rd_addr[0]  = 32'($urandom_range(0, 31)) << 2;
            pc_addr[0]  = 32'($urandom_range(0, 32'h1FFF));
            cyc(0, $sformatf("rand_cpu%0d", i));
        end
        wr_valid[0] = 1'b0;

        // 4: illegal writes
        rd_addr[0] = 32'h10;
        cpu_write(0, 32'h12, 32'hCAFE_0001, 32'h10, "wr_misaligned");
        cyc(0, "after_misaligned");
        cpu_write(0, 32'h1000, 32'hCAFE_0002, 32'h10, "wr_out_of_range");
        cyc(0, "after_out_of_range");

        // 2: partial load; wr_valid during LOAD must not fault
        do_reset(0, "reset2");
        wr_valid[0] = 1'b1; wr_addr[0] = 32'h13;
        send_byte(0, 8'hAA, 1'b0, "load2_aa");
        wr_valid[0] = 1'b0;
        send_byte(0, 8'hBB, 1'b1, "load2_bb");
        pc_addr[0] = 32'h0;
        cyc(0, "load2_pc0");
        pc_addr[0] = 32'h2000;
        cyc(0, "load2_pc_out_of_range");
        pc_addr[0] = 32'h3;
        cyc(0, "load2_pc_misaligned");

        // 6: reset mid-load discards the partial word
        do_reset(0, "reset6");
        send_byte(0, 8'h77, 1'b0, "load6_stale0");
        send_byte(0, 8'h88, 1'b0, "load6_stale1");
        do_reset(0, "reset6_mid");
        send_byte(0, 8'h11, 1'b0, "load6_11");
        send_byte(0, 8'h22, 1'b0, "load6_22");
        send_byte(0, 8'h33, 1'b0, "load6_33");
        send_byte(0, 8'h44, 1'b1, "load6_44");
        pc_addr[0] = 32'h0;
        cyc(0, "load6_readback");

        // random load with gaps, then read everything back
        do_reset(0, "reset_rand");
        nbytes = $urandom_range(5, 40);
        for (int i = 0; i < nbytes; i++) begin
            while ($urandom_range(0, 2) == 0) cyc(0, "rand_load_gap");
            send_byte(0, 8'($urandom), i == nbytes - 1, $sformatf("rand_load_b%0d", i));
        end
        nwords = (nbytes + 3) / 4;
        for (int i = 0; i < nwords; i++) begin
            pc_addr[0] = 32'(i) << 2;
            rd_addr[0] = 32'(nwords - 1 - i) << 2;
            cyc(0, $sformatf("rand_load_rd%0d", i));
        end

        // 5: auto-stop on the ADDR_W=2 instance
        for (int i = 0; i < 20; i++) begin
            ld_byte[1] = 8'($urandom); ld_valid[1] = 1'b1; ld_last[1] = 1'b0;
            cyc(1, $sformatf("auto_b%0d", i));
        end
        ld_valid[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_addr[1] = 32'(i) << 2;
            rd_addr[1] = 32'h10;
            cyc(1, $sformatf("auto_rd%0d", i));
        end
        cpu_write(1, 32'h10, 32'h5555_AAAA, 32'h0, "small_wr_out_of_range");
        cyc(1, "small_after_fault");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
